// File: rtl/prog_encoder.sv
// prog_encoder: encodes symbolic instruction requests into 9-bit words and writes them to instruction memory.
// Latency: a request accepted at edge N is written (wr_en/wr_addr/wr_data) in the cycle after edge N.
// Backpressure: in_ready is high only in LOAD; memory never stalls. Optional checksum: PROG_ENCODER_CHECKSUM_EN.
module prog_encoder #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_mnem,
  input  logic [5:0]    in_arg,
  input  logic          in_last,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [8:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic [AW:0]   count,
  output logic          err_illegal,
  output logic [8:0]    checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // count value just before the word that fills the last memory slot
  localparam logic [AW:0] LAST_SLOT = {1'b0, {AW{1'b1}}};

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic       legal;
  logic       write;
  logic       at_cap;
  logic       start_session;
  logic [8:0] enc;

  assign in_ready      = (state == S_LOAD);
  assign busy          = (state == S_LOAD) || (state == S_FLUSH);
  assign done          = (state == S_DONE);
  assign accept        = in_valid && in_ready;
  assign legal         = (in_mnem <= 4'd8);
  assign write         = accept && legal;
  assign at_cap        = (count == LAST_SLOT);
  assign start_session = start && ((state == S_IDLE) || (state == S_DONE));

  // Mnemonic to machine word; shifts share opcode 111 and put direction in bit 2
  always_comb begin
    enc = 9'd0;
    case (in_mnem)
      4'd7:    enc = {3'b111, in_arg[5:3], 1'b0, in_arg[1:0]};
      4'd8:    enc = {3'b111, in_arg[5:3], 1'b1, in_arg[1:0]};
      default: enc = {in_mnem[2:0], in_arg};
    endcase
  end

  // Load state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: session ends on last request or on filling the final slot
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (accept && (in_last || (legal && at_cap))) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write port, word counter (low bits double as write pointer) and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 9'd0;
      count       <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      wr_en <= write;
      if (write) begin
        wr_addr <= count[AW-1:0];
        wr_data <= enc;
        count   <= count + 1'b1;
        if (at_cap) full <= 1'b1;
      end
      if (accept && !legal) err_illegal <= 1'b1;
      if (start_session) begin
        count       <= '0;
        full        <= 1'b0;
        err_illegal <= 1'b0;
      end
    end
  end

`ifdef PROG_ENCODER_CHECKSUM_EN
  // Running XOR of every word written this session, updated alongside the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             checksum <= 9'd0;
    else if (start_session) checksum <= 9'd0;
    else if (write)         checksum <= checksum ^ enc;
  end
`else
  assign checksum = 9'd0;
`endif

endmodule
